// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS load/store unit: request ops,
// access sizes, FSM states and the alignment rule.
package mips_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_STORE = 2'd1,
      OP_LL    = 2'd2,
      OP_SC    = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CMD    = 2'd1,
      ST_RDWAIT = 2'd2,
      ST_RESP   = 2'd3
   } state_e;

   // A dword is only legal on a 64-bit memory bus.
   function automatic logic is_aligned(
      input size_e      sz,
      input logic [2:0] lo,
      input logic       dw64
   );
      logic ok;
      case (sz)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~lo[0];
         SZ_WORD: ok = (lo[1:0] == 2'b00);
         default: ok = dw64 && (lo == 3'b000);
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Big-endian lane steering: byte enables, store replication,
// load field extract with zero/sign extension.
module mips_lsu_align
   import mips_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  size_e                       i_size,
   input  logic [$clog2(DATA_W/8)-1:0] i_off,
   input  logic                        i_signext,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [DATA_W-1:0]           i_rdata,
   output logic [DATA_W/8-1:0]         o_be,
   output logic [DATA_W-1:0]          o_wdata,
   output logic [DATA_W-1:0]          o_rdata
);

   localparam int NB = DATA_W / 8;

   always_comb begin : p_lane
      int   n;
      int   src;
      logic sgn;
      n       = 1 << i_size;
      if (n > NB) n = NB;
      src     = 0;
      sgn     = 1'b0;
      o_be    = '0;
      o_wdata = i_wdata;
      o_rdata = '0;

      // Offset 0 is the most significant lane, so lane i holds offset NB-1-i.
      for (int i = 0; i < NB; i++) begin
         o_be[i] = ((NB - 1 - i) >= int'(i_off)) &&
                   ((NB - 1 - i) < (int'(i_off) + n));
      end

      case (i_size)
         SZ_BYTE:
            for (int i = 0; i < NB; i++)
               o_wdata[8*i +: 8] = i_wdata[7:0];
         SZ_HALF:
            for (int i = 0; i < NB/2; i++)
               o_wdata[16*i +: 16] = i_wdata[15:0];
         SZ_WORD:
            for (int i = 0; i < NB/4; i++)
               o_wdata[32*i +: 32] = i_wdata[31:0];
         default:
            o_wdata = i_wdata;
      endcase

      for (int k = 0; k < NB; k++) begin
         src = int'(i_off) + n - 1 - k;
         if ((k < n) && (src >= 0) && (src < NB))
            o_rdata[8*k +: 8] = i_rdata[8*(NB-1-src) +: 8];
      end

      sgn = i_signext & o_rdata[8*n-1];
      for (int k = 0; k < NB; k++) begin
         if (k >= n)
            o_rdata[8*k +: 8] = {8{sgn}};
      end
   end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one outstanding access, big-endian lanes,
// LL/SC reservation, flush and misalignment handling.
module mips_lsu
   import mips_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 32,
   parameter bit LLSC_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [1:0]          req_size,
   input  logic                req_signext,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [4:0]          req_rd,
   output logic                mem_req,
   input  logic                mem_gnt,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W/8-1:0] mem_be,
   output logic                mem_we,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic                mem_rvalid,
   input  logic [DATA_W-1:0]   mem_rdata,
   output logic                rsp_valid,
   output logic                rsp_we,
   output logic [4:0]          rsp_rd,
   output logic [DATA_W-1:0]   rsp_data,
   output logic                stall,
   output logic                misalign,
   input  logic                flush
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);
   localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

   state_e              r_state;
   op_e                 r_op;
   size_e               r_size;
   logic                r_signext;
   logic [OFF_W-1:0]    r_off;
   logic [4:0]          r_rd;
   logic                r_kill;
   logic                r_mem_req;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [NB-1:0]       r_mem_be;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_rsp_valid;
   logic                r_rsp_we;
   logic [4:0]          r_rsp_rd;
   logic [DATA_W-1:0]   r_rsp_data;
   logic                r_misalign;
   logic                r_resv_vld;
   logic [ADDR_W-3:0]   r_resv_addr;

   op_e                 w_op;
   size_e               w_size;
   logic                w_idle;
   logic                w_accept;
   logic                w_mis;
   logic                w_resv_hit;
   logic                w_is_wr;
   logic                w_r_is_rd;
   size_e               w_al_size;
   logic [OFF_W-1:0]    w_al_off;
   logic [NB-1:0]       w_be;
   logic [DATA_W-1:0]   w_wdata;
   logic [DATA_W-1:0]   w_rdata;

   assign w_op       = op_e'(req_op);
   assign w_size     = size_e'(req_size);
   assign w_idle     = (r_state == ST_IDLE);
   assign w_accept   = req_valid & w_idle & rst_n;
   assign w_mis      = ~is_aligned(w_size, req_addr[2:0], DATA_W == 64);
   assign w_resv_hit = r_resv_vld &&
                       (req_addr[ADDR_W-1:2] == r_resv_addr);
   assign w_is_wr    = (w_op == OP_STORE) || (w_op == OP_SC);
   assign w_r_is_rd  = (r_op == OP_LOAD) || (r_op == OP_LL);

   // Steering sees the live request in IDLE and the latched one later.
   assign w_al_size  = w_idle ? w_size : r_size;
   assign w_al_off   = w_idle ? req_addr[OFF_W-1:0] : r_off;

   mips_lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_size    (w_al_size),
      .i_off     (w_al_off),
      .i_signext (r_signext),
      .i_wdata   (req_wdata),
      .i_rdata   (mem_rdata),
      .o_be      (w_be),
      .o_wdata   (w_wdata),
      .o_rdata   (w_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_op        <= OP_LOAD;
         r_size      <= SZ_BYTE;
         r_signext   <= 1'b0;
         r_off       <= '0;
         r_rd        <= '0;
         r_kill      <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_be    <= '0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_we    <= 1'b0;
         r_rsp_rd    <= '0;
         r_rsp_data  <= '0;
         r_misalign  <= 1'b0;
         r_resv_vld  <= 1'b0;
         r_resv_addr <= '0;
      end else begin
         r_misalign  <= 1'b0;
         r_rsp_valid <= 1'b0;
         unique case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op      <= w_op;
                  r_size    <= w_size;
                  r_signext <= req_signext;
                  r_off     <= req_addr[OFF_W-1:0];
                  r_rd      <= req_rd;
                  r_kill    <= 1'b0;
                  if (w_mis) begin
                     r_misalign <= 1'b1;
                  end else if (LLSC_EN && (w_op == OP_SC) && !w_resv_hit) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_we    <= 1'b1;
                     r_rsp_rd    <= req_rd;
                     r_rsp_data  <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_mem_req   <= 1'b1;
                     r_mem_addr  <= req_addr;
                     r_mem_be    <= w_be;
                     r_mem_we    <= w_is_wr;
                     r_mem_wdata <= w_wdata;
                     r_state     <= ST_CMD;
                  end
               end
            end
            ST_CMD: begin
               if (mem_gnt) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_be  <= '0;
                  if (w_r_is_rd) begin
                     r_kill  <= flush;
                     r_state <= ST_RDWAIT;
                  end else begin
                     r_rsp_valid <= ~flush;
                     r_rsp_we    <= (r_op == OP_SC);
                     r_rsp_rd    <= r_rd;
                     r_rsp_data  <= (r_op == OP_SC) ? ONE : '0;
                     r_state     <= ST_RESP;
                  end
               end else if (flush) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_mem_be  <= '0;
                  r_state   <= ST_IDLE;
               end
            end
            ST_RDWAIT: begin
               if (mem_rvalid) begin
                  r_rsp_valid <= ~(r_kill | flush);
                  r_rsp_we    <= 1'b1;
                  r_rsp_rd    <= r_rd;
                  r_rsp_data  <= w_rdata;
                  r_state     <= ST_RESP;
               end else if (flush) begin
                  r_kill <= 1'b1;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase

         if (LLSC_EN && w_accept) begin
            if ((w_op == OP_LL) && !w_mis) begin
               r_resv_vld  <= 1'b1;
               r_resv_addr <= req_addr[ADDR_W-1:2];
            end else if ((w_op == OP_SC) ||
                         ((w_op == OP_STORE) && w_resv_hit)) begin
               r_resv_vld <= 1'b0;
            end
         end
         if (flush) r_resv_vld <= 1'b0;
      end
   end

   assign req_ready = w_idle;
   assign stall     = ~w_idle | w_accept;
   assign mem_req   = r_mem_req;
   assign mem_addr  = r_mem_addr;
   assign mem_be    = r_mem_be;
   assign mem_we    = r_mem_we;
   assign mem_wdata = r_mem_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_we    = r_rsp_we;
   assign rsp_rd    = r_rsp_rd;
   assign rsp_data  = r_rsp_data;
   assign misalign  = r_misalign;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed scoreboard bench for mips_lsu (32-bit data, LL/SC on).
module tb_mips_lsu;
   import mips_pkg::*;

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      bit          chk_d;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_op = '0;
   logic [1:0]  req_size = '0;
   logic        req_signext = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_we;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic        stall;
   logic        misalign;
   logic        flush = 1'b0;

   int checks = 0;
   int failures = 0;
   int n_cmd = 0;
   int n_rsp = 0;
   int n_mis = 0;
   int req_cycles = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int last_lat = 0;
   int gnt_delay = 0;
   int wait_cnt = 0;
   bit no_rvalid = 1'b0;
   bit rd_pend = 1'b0;
   logic [31:0] rd_val = '0;
   logic [31:0] exp_addr = '0;
   logic        exp_we = 1'b0;
   logic [3:0]  exp_be = '0;
   logic [31:0] exp_wdata = '0;
   exp_t exp_q[$];

   mips_lsu #(
      .DATA_W  (32),
      .ADDR_W  (32),
      .LLSC_EN (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_size    (req_size),
      .req_signext (req_signext),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rd      (req_rd),
      .mem_req     (mem_req),
      .mem_gnt     (mem_gnt),
      .mem_addr    (mem_addr),
      .mem_be      (mem_be),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_we      (rsp_we),
      .rsp_rd      (rsp_rd),
      .rsp_data    (rsp_data),
      .stall       (stall),
      .misalign    (misalign),
      .flush       (flush)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_rsp(input logic [4:0] rd, input logic we,
                             input logic [31:0] d, input bit cd);
      exp_t e;
      e.rd = rd; e.we = we; e.data = d; e.chk_d = cd;
      exp_q.push_back(e);
   endtask

   task automatic issue(input logic [1:0] op, input logic [1:0] sz,
                        input logic se, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      exp_addr    = a;
      exp_we      = (op == OP_STORE) || (op == OP_SC);
      req_valid   = 1'b1;
      req_op      = op;
      req_size    = sz;
      req_signext = se;
      req_addr    = a;
      req_wdata   = wd;
      req_rd      = rd;
      acc_cyc     = cyc;
      #1;
      chk("accept_ready", req_ready, 1);
      chk("accept_stall", stall, 1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((stall || mem_req) && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("idle_timeout", t < 100, 1);
      @(negedge clk);
   endtask

   // Memory model: grant after gnt_delay request cycles, rvalid one cycle later.
   initial begin
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_rvalid = 1'b0;
         if (!rst_n) begin
            mem_gnt = 1'b0;
            wait_cnt = 0;
            rd_pend = 1'b0;
         end else begin
            if (rd_pend) begin
               mem_rvalid = 1'b1;
               mem_rdata = rd_val;
               rd_pend = 1'b0;
            end
            if (mem_gnt) begin
               mem_gnt = 1'b0;
               wait_cnt = 0;
            end else if (mem_req) begin
               req_cycles++;
               chk("cmd_stall", stall, 1);
               chk("cmd_addr", mem_addr, exp_addr);
               chk("cmd_we", mem_we, exp_we);
               if (exp_we) begin
                  chk("cmd_be", mem_be, exp_be);
                  chk("cmd_wdata", mem_wdata, exp_wdata);
               end
               if (wait_cnt >= gnt_delay) begin
                  mem_gnt = 1'b1;
                  n_cmd++;
                  if (!mem_we && !no_rvalid) rd_pend = 1'b1;
               end else begin
                  wait_cnt++;
               end
            end else begin
               wait_cnt = 0;
            end
         end
      end
   end

   // Response scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && misalign) n_mis++;
         if (rst_n && rsp_valid) begin
            n_rsp++;
            last_lat = cyc - acc_cyc;
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("rsp_rd", rsp_rd, e.rd);
               chk("rsp_we", rsp_we, e.we);
               if (e.chk_d) chk("rsp_data", rsp_data, e.data);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0, r0, m0;
      logic [31:0] ld_addr [6];
      logic [1:0]  ld_size [6];
      logic        ld_se   [6];
      logic [31:0] ld_mem  [6];
      logic [31:0] ld_exp  [6];
      ld_addr = '{32'h2000, 32'h2002, 32'h2002, 32'h2000, 32'h2003, 32'h2000};
      ld_size = '{2'd2, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
      ld_se   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      ld_mem  = '{32'h80000001, 32'h1234F678, 32'h1234F678,
                  32'h7234F678, 32'h1234F6A8, 32'h80000000};
      ld_exp  = '{32'h80000001, 32'h0000F678, 32'hFFFFF678,
                  32'h00007234, 32'h000000A8, 32'hFFFFFF80};

      repeat (3) @(negedge clk);
      req_valid = 1'b1;
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_misalign", misalign, 0);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // LB with sign extension, minimum latency
      gnt_delay = 0;
      rd_val = 32'h11F23344;
      expect_rsp(5'd5, 1'b1, 32'hFFFFFFF2, 1'b1);
      issue(OP_LOAD, SZ_BYTE, 1'b1, 32'h1001, 32'h0, 5'd5);
      wait_idle();
      chk("lb_latency", last_lat, 3);

      // SH replication and byte enables
      c0 = n_cmd; r0 = n_rsp;
      exp_be = 4'b0011; exp_wdata = 32'hABCDABCD;
      expect_rsp(5'd6, 1'b0, 32'h0, 1'b0);
      issue(OP_STORE, SZ_HALF, 1'b0, 32'h2002, 32'h0000ABCD, 5'd6);
      wait_idle();
      chk("sh_cmds", n_cmd - c0, 1);
      chk("sh_rsps", n_rsp - r0, 1);

      for (int i = 0; i < 6; i++) begin
         rd_val = ld_mem[i];
         expect_rsp(5'(i + 16), 1'b1, ld_exp[i], 1'b1);
         issue(OP_LOAD, ld_size[i], ld_se[i], ld_addr[i], 32'h0, 5'(i + 16));
         wait_idle();
      end

      // LL then two SCs
      rd_val = 32'hCAFEBABE;
      expect_rsp(5'd7, 1'b1, 32'hCAFEBABE, 1'b1);
      issue(OP_LL, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd7);
      wait_idle();
      c0 = n_cmd;
      exp_be = 4'hF; exp_wdata = 32'h00000055;
      expect_rsp(5'd8, 1'b1, 32'h1, 1'b1);
      issue(OP_SC, SZ_WORD, 1'b0, 32'h100, 32'h55, 5'd8);
      wait_idle();
      chk("sc_ok_cmd", n_cmd - c0, 1);
      c0 = n_cmd;
      expect_rsp(5'd9, 1'b1, 32'h0, 1'b1);
      issue(OP_SC, SZ_WORD, 1'b0, 32'h100, 32'h66, 5'd9);
      wait_idle();
      chk("sc_fail_nocmd", n_cmd - c0, 0);

      // LL, SW to reserved word, SC fails
      c0 = n_cmd;
      rd_val = 32'h1;
      expect_rsp(5'd10, 1'b1, 32'h1, 1'b1);
      issue(OP_LL, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd10);
      wait_idle();
      exp_be = 4'hF; exp_wdata = 32'h0000DEAD;
      expect_rsp(5'd11, 1'b0, 32'h0, 1'b0);
      issue(OP_STORE, SZ_WORD, 1'b0, 32'h100, 32'hDEAD, 5'd11);
      wait_idle();
      expect_rsp(5'd12, 1'b1, 32'h0, 1'b1);
      issue(OP_SC, SZ_WORD, 1'b0, 32'h100, 32'h77, 5'd12);
      wait_idle();
      chk("sw_sc_cmds", n_cmd - c0, 2);

      // Misaligned LW
      c0 = n_cmd; r0 = n_rsp; m0 = n_mis;
      issue(OP_LOAD, SZ_WORD, 1'b0, 32'h3, 32'h0, 5'd3);
      chk("mis_pulse", misalign, 1);
      chk("mis_no_req", mem_req, 0);
      chk("mis_no_rsp", rsp_valid, 0);
      @(negedge clk);
      chk("mis_one_cycle", misalign, 0);
      wait_idle();
      chk("mis_count", n_mis - m0, 1);
      chk("mis_cmds", n_cmd - c0, 0);
      chk("mis_rsps", n_rsp - r0, 0);

      // Grant held off for 5 cycles
      gnt_delay = 5; req_cycles = 0;
      exp_be = 4'hF; exp_wdata = 32'h12345678;
      expect_rsp(5'd13, 1'b0, 32'h0, 1'b0);
      issue(OP_STORE, SZ_WORD, 1'b0, 32'h40, 32'h12345678, 5'd13);
      wait_idle();
      chk("gnt_wait_cycles", req_cycles, 6);

      // Flush in CMD before grant
      gnt_delay = 3;
      c0 = n_cmd; r0 = n_rsp;
      issue(OP_LOAD, SZ_WORD, 1'b0, 32'h60, 32'h0, 5'd14);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_cmd_drop", mem_req, 0);
      wait_idle();
      chk("flush_cmd_nocmd", n_cmd - c0, 0);
      chk("flush_cmd_norsp", n_rsp - r0, 0);

      // Flush after grant
      gnt_delay = 0;
      c0 = n_cmd; r0 = n_rsp;
      rd_val = 32'h5A5A5A5A;
      issue(OP_LOAD, SZ_WORD, 1'b0, 32'h60, 32'h0, 5'd15);
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      wait_idle();
      chk("flush_gnt_cmd", n_cmd - c0, 1);
      chk("flush_gnt_norsp", n_rsp - r0, 0);

      // Flush clears the reservation
      rd_val = 32'h2;
      expect_rsp(5'd20, 1'b1, 32'h2, 1'b1);
      issue(OP_LL, SZ_WORD, 1'b0, 32'h200, 32'h0, 5'd20);
      wait_idle();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      c0 = n_cmd;
      expect_rsp(5'd21, 1'b1, 32'h0, 1'b1);
      issue(OP_SC, SZ_WORD, 1'b0, 32'h200, 32'h1, 5'd21);
      wait_idle();
      chk("flush_sc_nocmd", n_cmd - c0, 0);

      // Reset during RDWAIT, then SC after LL must fail
      rd_val = 32'h3;
      expect_rsp(5'd22, 1'b1, 32'h3, 1'b1);
      issue(OP_LL, SZ_WORD, 1'b0, 32'h100, 32'h0, 5'd22);
      wait_idle();
      no_rvalid = 1'b1;
      r0 = n_rsp;
      issue(OP_LOAD, SZ_WORD, 1'b0, 32'h50, 32'h0, 5'd23);
      @(negedge clk);
      chk("rdwait_stall", stall, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", req_ready, 1);
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_mem_req", mem_req, 0);
      chk("mid_rst_mem_addr", mem_addr, 0);
      chk("mid_rst_mem_wdata", mem_wdata, 0);
      chk("mid_rst_rsp_rd", rsp_rd, 0);
      chk("mid_rst_rsp_we", rsp_we, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      no_rvalid = 1'b0;
      repeat (5) @(negedge clk);
      chk("rst_abandon_norsp", n_rsp - r0, 0);
      c0 = n_cmd;
      expect_rsp(5'd24, 1'b1, 32'h0, 1'b1);
      issue(OP_SC, SZ_WORD, 1'b0, 32'h100, 32'h9, 5'd24);
      wait_idle();
      chk("rst_sc_nocmd", n_cmd - c0, 0);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 SHALL have parameter DATA_W, default 32, memory data width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter LLSC_EN, default 1, enabling the LL/SC reservation logic.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port req_valid / req_ready, input / output, 1 each, EX-side request handshake.
REQ-007 SHALL have port req_op, input, 2, request kind: 0 load, 1 store, 2 LL, 3 SC.
REQ-008 SHALL have port req_size, input, 2, access size: 0 byte, 1 half, 2 word, 3 dword (DATA_W=64 only).
REQ-009 SHALL have ports req_signext (input, 1), req_addr (input, ADDR_W), req_wdata (input, DATA_W), req_rd (input, 5): sign-extend flag, address, store data, destination register.
REQ-010 SHALL have ports mem_req (output, 1), mem_gnt (input, 1), mem_addr (output, ADDR_W), mem_be (output, DATA_W/8), mem_we (output, 1), mem_wdata (output, DATA_W): memory command channel.
REQ-011 SHALL have ports mem_rvalid (input, 1) and mem_rdata (input, DATA_W): memory read return.
REQ-012 SHALL have ports rsp_valid (output, 1), rsp_we (output, 1), rsp_rd (output, 5), rsp_data (output, DATA_W): writeback response.
REQ-013 SHALL have ports stall (output, 1), misalign (output, 1), flush (input, 1).

Function
REQ-014 SHALL implement FSM states IDLE, CMD (mem_req high, waiting mem_gnt), RDWAIT (waiting mem_rvalid), RESP (rsp_valid high for one cycle).
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted when req_valid and req_ready are both high.
REQ-016 SHALL hold mem_req, mem_addr, mem_be, mem_we and mem_wdata stable in CMD until mem_gnt; a grant on the first CMD cycle is legal.
REQ-017 SHALL go from CMD to RDWAIT after grant for load/LL, and to RESP for store/SC.
REQ-018 SHALL go from RDWAIT to RESP on mem_rvalid and capture mem_rdata that cycle; mem_rvalid in the same cycle as mem_gnt is not legal.
REQ-019 SHALL use big-endian lane order: byte offset 0 maps to the most significant byte lane.
REQ-020 SHALL generate mem_be and replicate store data across lanes per req_size and the low address bits.
REQ-021 SHALL extract the loaded field and zero- or sign-extend it to DATA_W per req_signext.
REQ-022 SHALL treat an address not aligned to its size as misaligned: pulse misalign for one cycle, issue no memory command, return to IDLE, and set rsp_valid=0.
REQ-023 SHALL, on LL (LLSC_EN=1), set the reservation valid bit and record addr[ADDR_W-1:2].
REQ-024 SHALL write on SC only if the reservation is valid and the address matches; otherwise SC issues no command and goes straight to RESP.
REQ-025 SHALL return rsp_data = 1 for a successful SC and 0 for a failed SC, with rsp_we=1.
REQ-026 SHALL clear the reservation on any SC, on any store to the reserved word, and on flush.
REQ-027 SHALL, when LLSC_EN=0, treat LL as a load and SC as a store that always returns 1.
REQ-028 SHALL assert rsp_we=1 for loads, LL and SC, and 0 for stores.
REQ-029 SHALL assert stall in every cycle from acceptance until the RESP cycle, inclusive.
REQ-030 SHALL give a minimum latency of 3 cycles from acceptance to rsp_valid for a load with immediate grant and next-cycle rvalid.
REQ-031 SHALL, on flush in CMD before grant, drop the command and return to IDLE with no response.
REQ-032 SHALL, on flush after grant, complete the memory handshake but suppress rsp_valid.

Reset
REQ-033 SHALL, while rst_n is low, force: state IDLE; reservation invalid; req_ready=1; mem_req, mem_we, mem_be, rsp_valid, rsp_we, stall and misalign all 0; rsp_data, rsp_rd, mem_addr and mem_wdata all 0.
REQ-034 SHALL abandon any in-flight transaction when reset is asserted mid-operation, with no response after release.

Structure
REQ-035 SHALL take the op encodings, size encodings and FSM state encoding from a shared package, mips_pkg.
REQ-036 SHALL place lane steering (byte enables, store replication, load extract/extend) in one combinational sub-module, mips_lsu_align.

Verification
REQ-037 SHALL cover: LB from addr 0x1001 with mem_rdata 0x11F23344, signext=1 -> rsp_data 0xFFFFFFF2 after 3 cycles.
REQ-038 SHALL cover: SH of 0xABCD to addr 0x2002 -> mem_be 4'b0011, mem_wdata 0xABCDABCD, rsp_we 0.
REQ-039 SHALL cover: LL 0x100, then SC 0x100 -> write issued and rsp_data 1; a second SC -> no command and rsp_data 0.
REQ-040 SHALL cover: LL 0x100, SW 0x100, SC 0x100 -> SC fails with rsp_data 0.
REQ-041 SHALL cover: LW to 0x3 -> misalign pulse, no mem_req, rsp_valid 0.
REQ-042 SHALL cover: mem_gnt held low for 5 cycles -> command stable and stall high throughout; rst_n low during RDWAIT -> IDLE with no response.
